wb_j1_data_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single shared-RAM Wishbone data port among NUM_CPU j1 cores.

---
 rtl/wb_j1_data_arbiter_pkg.sv | 12 +
 rtl/wb_j1_data_arbiter_if.sv | 35 +++
 rtl/wb_j1_data_arbiter_picker.sv | 31 +++
 rtl/wb_j1_data_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_j1_data_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/wb_j1_data_arbiter_pkg.sv
// Shared constants for the j1 data-port arbiter: bus widths and FSM state encodings.
package wb_j1_data_arbiter_pkg;

  localparam int PC_WIDTH   = 16;
  localparam int DATA_WIDTH = 32;

  localparam int ARB_STATE_W = 2;
  localparam logic [ARB_STATE_W-1:0] ARB_IDLE = 2'd0;
  localparam logic [ARB_STATE_W-1:0] ARB_BUS  = 2'd1;
  localparam logic [ARB_STATE_W-1:0] ARB_TOUT = 2'd2;

endpackage

// File: rtl/wb_j1_data_arbiter_if.sv
// Bundle of the per-core request side, the shared RAM port and the arbiter status outputs.
interface wb_j1_data_arbiter_if
  import wb_j1_data_arbiter_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = PC_WIDTH,
  parameter int DATA_W  = DATA_WIDTH
);
  logic [NUM_CPU-1:0]        m_cyc_i;
  logic [NUM_CPU-1:0]        m_we_i;
  logic [NUM_CPU*ADDR_W-1:0] m_adr_i;
  logic [NUM_CPU*DATA_W-1:0] m_dat_i;
  logic [NUM_CPU-1:0]        m_ack_o;
  logic [DATA_W-1:0]         m_dat_o;
  logic                      s_cyc_o;
  logic                      s_we_o;
  logic [ADDR_W-1:0]         s_adr_o;
  logic [DATA_W-1:0]         s_dat_o;
  logic [DATA_W-1:0]         s_dat_i;
  logic                      s_ack_i;
  logic [NUM_CPU-1:0]        grant_o;
  logic                      err_o;
  logic [2:0]                err_id_o;

  // The arbiter itself: slave to the cores, master of the RAM port.
  modport slave (
    input  m_cyc_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_ack_o, m_dat_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o, grant_o, err_o, err_id_o
  );

  modport master (
    output m_cyc_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_ack_o, m_dat_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o, grant_o, err_o, err_id_o
  );
endinterface

// File: rtl/wb_j1_data_arbiter_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr_i.
module wb_rr_picker
  import wb_j1_data_arbiter_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int PTR_W   = $clog2(NUM_CPU)
) (
  input  logic [NUM_CPU-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_CPU-1:0] gnt_o,
  output logic               valid_o
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites the others.
  always_comb begin
    gnt_o = '0;
    for (int k = NUM_CPU - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_CPU; j++) begin
        if (req_i[j] && (j == ((int'(ptr_i) + k) % NUM_CPU))) begin
          gnt_o    = '0;
          gnt_o[j] = 1'b1;
        end else begin
          gnt_o = gnt_o;
        end
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/wb_j1_data_arbiter.sv
// Round-robin arbiter sharing one Wishbone RAM data port among NUM_CPU j1 cores,
// with a watchdog that terminates transfers the RAM never acknowledges.
module wb_j1_data_arbiter
  import wb_j1_data_arbiter_pkg::*;
#(
  parameter int                 NUM_CPU     = 4,
  parameter int                 ADDR_W      = PC_WIDTH,
  parameter int                 DATA_W      = DATA_WIDTH,
  parameter int                 TIMEOUT     = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_DAT = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  wb_j1_data_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_CPU);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [ARB_STATE_W-1:0] state_q, state_d;
  logic [NUM_CPU-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   err_q, err_d;
  logic [2:0]             err_id_q, err_id_d;

  logic [NUM_CPU-1:0] pick_gnt_s;
  logic               pick_valid_s;
  logic [PTR_W-1:0]   g_idx_s;
  logic [PTR_W-1:0]   nxt_ptr_s;
  logic               g_cyc_s;
  logic               s_we_s;
  logic [ADDR_W-1:0]  s_adr_s;
  logic [DATA_W-1:0]  s_dat_s;
  logic [NUM_CPU-1:0] m_ack_s;
  logic [DATA_W-1:0]  m_dat_s;

  wb_rr_picker #(.NUM_CPU(NUM_CPU), .PTR_W(PTR_W)) u_picker (
    .req_i   (bus.m_cyc_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt_s),
    .valid_o (pick_valid_s)
  );

  // grant_q is zero in IDLE, so the masked OR-mux drives the RAM port to zero there.
  always_comb begin
    g_idx_s = '0;
    s_we_s  = 1'b0;
    s_adr_s = '0;
    s_dat_s = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      if (grant_q[i]) begin
        g_idx_s = PTR_W'(i);
        s_we_s  = s_we_s | bus.m_we_i[i];
        s_adr_s = s_adr_s | bus.m_adr_i[i*ADDR_W +: ADDR_W];
        s_dat_s = s_dat_s | bus.m_dat_i[i*DATA_W +: DATA_W];
      end else begin
        g_idx_s = g_idx_s;
      end
    end
  end

  assign g_cyc_s   = |(grant_q & bus.m_cyc_i);
  assign nxt_ptr_s = (g_idx_s == PTR_W'(NUM_CPU - 1)) ? '0 : g_idx_s + PTR_W'(1);

  // Ack and read data are combinational so the core samples them on the acking edge.
  always_comb begin
    m_ack_s = '0;
    m_dat_s = '0;
    case (state_q)
      ARB_BUS: begin
        if (g_cyc_s && bus.s_ack_i) begin
          m_ack_s = grant_q;
          m_dat_s = bus.s_dat_i;
        end else begin
          m_ack_s = '0;
        end
      end
      ARB_TOUT: begin
        m_ack_s = grant_q;
        m_dat_s = TIMEOUT_DAT;
      end
      default: begin
        m_ack_s = '0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    err_id_d   = err_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          grant_d    = pick_gnt_s;
          wait_cnt_d = '0;
          state_d    = ARB_BUS;
        end else begin
          grant_d = '0;
        end
      end
      ARB_BUS: begin
        // A dropped cyc (abort) and a RAM ack both end the turn the same way.
        if (!g_cyc_s || bus.s_ack_i) begin
          state_d  = ARB_IDLE;
          grant_d  = '0;
          rr_ptr_d = nxt_ptr_s;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ARB_TOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ARB_TOUT: begin
        err_d    = 1'b1;
        err_id_d = 3'(g_idx_s);
        state_d  = ARB_IDLE;
        grant_d  = '0;
        rr_ptr_d = nxt_ptr_s;
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      err_id_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
    end
  end

  assign bus.s_cyc_o  = (state_q == ARB_BUS) && g_cyc_s;
  assign bus.s_we_o   = s_we_s;
  assign bus.s_adr_o  = s_adr_s;
  assign bus.s_dat_o  = s_dat_s;
  assign bus.m_ack_o  = m_ack_s;
  assign bus.m_dat_o  = m_dat_s;
  assign bus.grant_o  = grant_q;
  assign bus.err_o    = err_q;
  assign bus.err_id_o = err_id_q;

endmodule

// File: tb/tb_wb_j1_data_arbiter.sv
// Directed bench for wb_j1_data_arbiter: a per-cycle vector table plus hand-written
// sequences for timeout, abort and asynchronous reset.
module tb_wb_j1_data_arbiter;

  typedef struct {
    logic        rst;
    logic [3:0]  cyc;
    logic [3:0]  we;
    logic        ack;
    logic [31:0] sdi;
    logic        e_scyc;
    logic        e_swe;
    logic [15:0] e_adr;
    logic [31:0] e_sdo;
    logic [3:0]  e_ack;
    logic [31:0] e_mdat;
    logic [3:0]  e_gnt;
  } vec_t;

  localparam int NV = 27;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t vecs [NV];

  wb_j1_data_arbiter_if #(.NUM_CPU(4), .ADDR_W(16), .DATA_W(32)) bus ();

  wb_j1_data_arbiter #(
    .NUM_CPU(4), .ADDR_W(16), .DATA_W(32), .TIMEOUT(8), .TIMEOUT_DAT(32'hDEADBEEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [3:0] w,
                              input logic a, input logic [31:0] d, input logic sc,
                              input logic sw, input logic [15:0] ad, input logic [31:0] so,
                              input logic [3:0] ak, input logic [31:0] md, input logic [3:0] g);
    vec_t v;
    v.rst = r; v.cyc = c; v.we = w; v.ack = a; v.sdi = d;
    v.e_scyc = sc; v.e_swe = sw; v.e_adr = ad; v.e_sdo = so;
    v.e_ack = ak; v.e_mdat = md; v.e_gnt = g;
    return v;
  endfunction

  function automatic vec_t idl(input logic r, input logic [3:0] c, input logic [3:0] w,
                               input logic a, input logic [31:0] d);
    return mk(r, c, w, a, d, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 32'h0, 4'h0);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] w, input logic a, input logic [31:0] d);
    bus.m_cyc_i = c;
    bus.m_we_i  = w;
    bus.s_ack_i = a;
    bus.s_dat_i = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    bus.m_adr_i = {16'h0300, 16'h0040, 16'h0100, 16'h0010};
    bus.m_dat_i = {32'h11110003, 32'h11110002, 32'hCAFEF00D, 32'h11110000};

    // single read by core 2, then rr_ptr=3 makes core 3 win over core 0
    vecs[0]  = idl(1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0);
    vecs[1]  = idl(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    vecs[2]  = idl(1'b0, 4'b0100, 4'b0000, 1'b0, 32'h0);
    vecs[3]  = mk (1'b0, 4'b0100, 4'b0000, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h11110002, 4'b0000, 32'h0, 4'b0100);
    vecs[4]  = mk (1'b0, 4'b0100, 4'b0000, 1'b1, 32'h12345678, 1'b1, 1'b0, 16'h0040, 32'h11110002, 4'b0100, 32'h12345678, 4'b0100);
    vecs[5]  = idl(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    vecs[6]  = idl(1'b0, 4'b1001, 4'b0000, 1'b0, 32'h0);
    vecs[7]  = mk (1'b0, 4'b1001, 4'b0000, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 16'h0300, 32'h11110003, 4'b1000, 32'hA5A5A5A5, 4'b1000);
    vecs[8]  = idl(1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0);
    vecs[9]  = mk (1'b0, 4'b0001, 4'b0000, 1'b1, 32'h00000077, 1'b1, 1'b0, 16'h0010, 32'h11110000, 4'b0001, 32'h00000077, 4'b0001);
    vecs[10] = idl(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    // all four from reset, 1-cycle acks; acks during IDLE must be ignored
    vecs[11] = idl(1'b1, 4'b1111, 4'b0000, 1'b1, 32'h99);
    vecs[12] = idl(1'b0, 4'b1111, 4'b0000, 1'b1, 32'h99);
    vecs[13] = mk (1'b0, 4'b1111, 4'b0000, 1'b1, 32'hD0D00000, 1'b1, 1'b0, 16'h0010, 32'h11110000, 4'b0001, 32'hD0D00000, 4'b0001);
    vecs[14] = idl(1'b0, 4'b1110, 4'b0000, 1'b1, 32'hD1D10000);
    vecs[15] = mk (1'b0, 4'b1110, 4'b0000, 1'b1, 32'hD1D10000, 1'b1, 1'b0, 16'h0100, 32'hCAFEF00D, 4'b0010, 32'hD1D10000, 4'b0010);
    vecs[16] = idl(1'b0, 4'b1100, 4'b0000, 1'b1, 32'hD2D20000);
    vecs[17] = mk (1'b0, 4'b1100, 4'b0000, 1'b1, 32'hD2D20000, 1'b1, 1'b0, 16'h0040, 32'h11110002, 4'b0100, 32'hD2D20000, 4'b0100);
    vecs[18] = idl(1'b0, 4'b1000, 4'b0000, 1'b1, 32'hD3D30000);
    vecs[19] = mk (1'b0, 4'b1000, 4'b0000, 1'b1, 32'hD3D30000, 1'b1, 1'b0, 16'h0300, 32'h11110003, 4'b1000, 32'hD3D30000, 4'b1000);
    vecs[20] = idl(1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0);
    vecs[21] = mk (1'b0, 4'b0001, 4'b0000, 1'b1, 32'hD4D40000, 1'b1, 1'b0, 16'h0010, 32'h11110000, 4'b0001, 32'hD4D40000, 4'b0001);
    vecs[22] = idl(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    // core 1 write of 0xCAFEF00D to 0x0100
    vecs[23] = idl(1'b0, 4'b0010, 4'b0010, 1'b0, 32'h0);
    vecs[24] = mk (1'b0, 4'b0010, 4'b0010, 1'b0, 32'h0, 1'b1, 1'b1, 16'h0100, 32'hCAFEF00D, 4'b0000, 32'h0, 4'b0010);
    vecs[25] = mk (1'b0, 4'b0010, 4'b0010, 1'b1, 32'h0, 1'b1, 1'b1, 16'h0100, 32'hCAFEF00D, 4'b0010, 32'h0, 4'b0010);
    vecs[26] = idl(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);

    #2;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) tick();
      rst = vecs[i].rst;
      drive(vecs[i].cyc, vecs[i].we, vecs[i].ack, vecs[i].sdi);
      #1;
      chk($sformatf("vec%0d", i),
          {bus.s_cyc_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.m_ack_o, bus.m_dat_o, bus.grant_o, bus.err_o},
          {vecs[i].e_scyc, vecs[i].e_swe, vecs[i].e_adr, vecs[i].e_sdo, vecs[i].e_ack, vecs[i].e_mdat, vecs[i].e_gnt, 1'b0});
    end

    // timeout: core 3 (rr_ptr=2) wins over pending core 0, RAM never acks
    tick(); drive(4'b1001, 4'b0000, 1'b0, 32'h0); #1;
    chk("tout_idle", {bus.s_cyc_o, bus.grant_o}, {1'b0, 4'b0000});
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("tout_wait%0d", k), {bus.s_cyc_o, bus.m_ack_o, bus.grant_o, bus.m_dat_o}, {1'b1, 4'b0000, 4'b1000, 32'h0});
    end
    tick();
    chk("tout_ack", {bus.s_cyc_o, bus.m_ack_o, bus.m_dat_o, bus.err_o}, {1'b0, 4'b1000, 32'hDEADBEEF, 1'b0});
    tick(); drive(4'b0001, 4'b0000, 1'b0, 32'h0); #1;
    chk("tout_err", {bus.err_o, bus.err_id_o, bus.grant_o, bus.s_cyc_o, bus.m_ack_o}, {1'b1, 3'd3, 4'b0000, 1'b0, 4'b0000});
    tick();
    chk("tout_next", {bus.grant_o, bus.s_cyc_o}, {4'b0001, 1'b1});
    drive(4'b0001, 4'b0000, 1'b1, 32'h55); #1;
    chk("tout_next_ack", {bus.m_ack_o, bus.m_dat_o}, {4'b0001, 32'h55});

    // abort: core 0 drops cyc at wait_cnt=3 while core 1 is pending
    tick(); drive(4'b0001, 4'b0000, 1'b0, 32'h0); #1;
    chk("abort_idle", {bus.grant_o, bus.m_ack_o}, {4'b0000, 4'b0000});
    tick(); drive(4'b0011, 4'b0000, 1'b0, 32'h0); #1;
    chk("abort_gnt", {bus.grant_o, bus.s_cyc_o, bus.s_adr_o}, {4'b0001, 1'b1, 16'h0010});
    tick(); tick(); tick();
    drive(4'b0010, 4'b0000, 1'b0, 32'h0); #1;
    chk("abort_drop", {bus.s_cyc_o, bus.m_ack_o, bus.m_dat_o, bus.err_o}, {1'b0, 4'b0000, 32'h0, 1'b1});
    tick();
    chk("abort_turn", {bus.grant_o, bus.m_ack_o, bus.s_cyc_o}, {4'b0000, 4'b0000, 1'b0});
    tick();
    chk("abort_next", {bus.grant_o, bus.s_cyc_o, bus.s_adr_o}, {4'b0010, 1'b1, 16'h0100});
    drive(4'b0010, 4'b0000, 1'b1, 32'h0); #1;
    tick(); drive(4'b0000, 4'b0000, 1'b0, 32'h0);

    // async reset while core 2 is on the bus with the RAM acking
    tick(); drive(4'b0100, 4'b0000, 1'b0, 32'h0);
    tick(); drive(4'b0100, 4'b0000, 1'b1, 32'h13579BDF); #1;
    chk("rst_pre", {bus.m_ack_o, bus.m_dat_o, bus.err_id_o}, {4'b0100, 32'h13579BDF, 3'd3});
    #1 rst = 1'b1;
    #1;
    chk("rst_ctl", {bus.s_cyc_o, bus.s_we_o, bus.s_adr_o, bus.m_ack_o, bus.grant_o, bus.err_o, bus.err_id_o}, 128'h0);
    chk("rst_dat", {bus.s_dat_o, bus.m_dat_o}, 128'h0);
    tick(); rst = 1'b0; drive(4'b1111, 4'b0000, 1'b0, 32'h0); #1;
    chk("rst_idle", {bus.grant_o, bus.s_cyc_o}, {4'b0000, 1'b0});
    tick();
    chk("rst_ptr0", {bus.grant_o, bus.s_cyc_o, bus.err_o}, {4'b0001, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
